// File: rtl/atari_scan_doubler_if.sv
// Video bundle between the TIA-rate source and the scan doubler.
// The source drives the pixel side; the doubler drives the VGA side.
interface atari_scan_doubler_if;
    logic       PIX_CE;
    logic [7:0] COLORIN;
    logic       HSYNC_in;
    logic       HBLANK_in;
    logic       VSYNC_in;
    logic       VBLANK_in;
    logic [7:0] VGA_COLOR;
    logic       VGA_HSYNC;
    logic       VGA_VSYNC;
    logic       VGA_BLANK;
    logic       LOCKED;

    modport master (
        output PIX_CE, COLORIN, HSYNC_in,
        output HBLANK_in, VSYNC_in, VBLANK_in,
        input  VGA_COLOR, VGA_HSYNC, VGA_VSYNC,
        input  VGA_BLANK, LOCKED
    );

    modport slave (
        input  PIX_CE, COLORIN, HSYNC_in,
        input  HBLANK_in, VSYNC_in, VBLANK_in,
        output VGA_COLOR, VGA_HSYNC, VGA_VSYNC,
        output VGA_BLANK, LOCKED
    );
endinterface

// File: rtl/atari_scan_doubler.sv
// Line doubler: buffers each TIA line in a ping-pong RAM and
// replays it twice at the 2x clock as a VGA-style stream.
module atari_scan_doubler #(
    parameter int LINE_PIXELS = 160,
    parameter int HTOTAL      = 228,
    parameter int HSTART      = 68,
    parameter int HSYNC_LEN   = 16
) (
    input logic CLOCKVGA,
    input logic RES_n,
    atari_scan_doubler_if.slave vid
);
    localparam logic [7:0] LP      = 8'(LINE_PIXELS);
    localparam logic [7:0] OX_LAST = 8'(HTOTAL - 1);
    localparam logic [7:0] HS0     = 8'(HSTART);
    localparam logic [7:0] HSL     = 8'(HSYNC_LEN);
    localparam logic [9:0] PER_OK  = 10'(2 * HTOTAL - 1);
    localparam logic [9:0] PER_MAX = '1;

    logic [7:0] line_mem [0:1][0:LINE_PIXELS-1];

    logic       wr_sel_q, wr_sel_d;
    logic [7:0] wr_x_q, wr_x_d;
    logic [7:0] rd_len_q, rd_len_d;
    logic [7:0] ox_q, ox_d;
    logic       half_q, half_d;
    logic       hs_prev_q, hs_prev_d;
    logic       vs_l_q, vs_l_d;
    logic       vb_l_q, vb_l_d;
    logic [9:0] period_q, period_d;
    logic       locked_q, locked_d;
    logic [7:0] color_q, color_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       blank_q, blank_d;

    logic       line_start;
    logic       wr_en;
    logic [7:0] wr_x_base;
    logic [7:0] addr;
    logic [7:0] rd_idx;
    logic       vis;
    logic       pix_en;

    always_comb begin
        line_start = vid.PIX_CE & vid.HSYNC_in & ~hs_prev_q;
        hs_prev_d  = vid.PIX_CE ? vid.HSYNC_in : hs_prev_q;
        wr_sel_d   = line_start ? ~wr_sel_q : wr_sel_q;
        rd_len_d   = line_start ? wr_x_q : rd_len_q;
        vs_l_d     = line_start ? vid.VSYNC_in : vs_l_q;
        vb_l_d     = line_start ? vid.VBLANK_in : vb_l_q;

        // a pixel on the line-start clock lands at index 0 of the new buffer
        wr_x_base = line_start ? 8'd0 : wr_x_q;
        wr_en     = RES_n & vid.PIX_CE & ~vid.HBLANK_in
                  & (wr_x_base < LP);
        wr_x_d    = wr_en ? wr_x_base + 8'd1 : wr_x_base;

        ox_d   = ox_q + 8'd1;
        half_d = half_q;
        if (line_start) begin
            ox_d   = 8'd0;
            half_d = 1'b0;
        end else if (ox_q == OX_LAST) begin
            ox_d   = 8'd0;
            half_d = ~half_q;
        end

        period_d = (period_q == PER_MAX) ? period_q
                                         : period_q + 10'd1;
        locked_d = (period_q == PER_MAX) ? 1'b0 : locked_q;
        if (line_start) begin
            period_d = 10'd0;
            locked_d = (period_q == PER_OK);
        end

        addr    = ox_q - HS0;
        vis     = (ox_q >= HS0) & (addr < LP) & ~vb_l_q;
        pix_en  = vis & (addr < rd_len_q);
        rd_idx  = pix_en ? addr : 8'd0;
        hsync_d = (ox_q < HSL);
        vsync_d = vs_l_q;
        blank_d = ~vis;
        color_d = pix_en ? line_mem[~wr_sel_q][rd_idx] : 8'd0;
    end

    always_ff @(posedge CLOCKVGA) begin
        if (!RES_n) begin
            wr_sel_q  <= 1'b0;
            wr_x_q    <= 8'd0;
            rd_len_q  <= 8'd0;
            ox_q      <= 8'd0;
            half_q    <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_l_q    <= 1'b0;
            // keeps the first post-reset line fully blank
            vb_l_q    <= 1'b1;
            period_q  <= 10'd0;
            locked_q  <= 1'b0;
            color_q   <= 8'd0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            blank_q   <= 1'b1;
        end else begin
            wr_sel_q  <= wr_sel_d;
            wr_x_q    <= wr_x_d;
            rd_len_q  <= rd_len_d;
            ox_q      <= ox_d;
            half_q    <= half_d;
            hs_prev_q <= hs_prev_d;
            vs_l_q    <= vs_l_d;
            vb_l_q    <= vb_l_d;
            period_q  <= period_d;
            locked_q  <= locked_d;
            color_q   <= color_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_q   <= blank_d;
        end
    end

    always_ff @(posedge CLOCKVGA) begin
        if (wr_en) line_mem[wr_sel_d][wr_x_base] <= vid.COLORIN;
    end

    assign vid.VGA_COLOR = color_q;
    assign vid.VGA_HSYNC = hsync_q;
    assign vid.VGA_VSYNC = vsync_q;
    assign vid.VGA_BLANK = blank_q;
    assign vid.LOCKED    = locked_q;
endmodule

// File: tb/tb_atari_scan_doubler.sv
// Randomized bench for atari_scan_doubler against a line-level
// model: captured lines as queues, output phase as time modulo HTOTAL.
module tb_atari_scan_doubler;
    localparam int LP = 160;
    localparam int HT = 228;
    localparam int HST = 68;
    localparam int HSL = 16;

    logic clk;
    logic res_n;
    atari_scan_doubler_if vif ();

    atari_scan_doubler dut (
        .CLOCKVGA (clk),
        .RES_n    (res_n),
        .vid      (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit [7:0] cur[$];
    bit [7:0] prev[$];
    int ls_cyc;
    int evt_cyc;
    bit m_hs_prev;
    bit m_vs;
    bit m_vb;
    bit m_locked;

    int exp_color;
    int exp_hs;
    int exp_vs;
    int exp_blank;
    int exp_locked;

    task automatic check(input string tag, input int got,
                         input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        int ox;
        int idx;
        bit vis;
        bit ls;
        if (!res_n) begin
            exp_color = 0;
            exp_hs = 0;
            exp_vs = 0;
            exp_blank = 1;
            exp_locked = 0;
            ls_cyc = cyc;
            evt_cyc = cyc;
            prev.delete();
            cur.delete();
            m_hs_prev = 0;
            m_vs = 0;
            m_vb = 1;
            m_locked = 0;
            return;
        end
        ox = (cyc - 1 - ls_cyc) % HT;
        idx = ox - HST;
        vis = (ox >= HST) && (idx < LP) && !m_vb;
        exp_hs = (ox < HSL) ? 1 : 0;
        exp_vs = m_vs;
        exp_blank = vis ? 0 : 1;
        exp_color = (vis && idx < prev.size()) ? prev[idx] : 0;

        ls = vif.PIX_CE && vif.HSYNC_in && !m_hs_prev;
        if (vif.PIX_CE) m_hs_prev = vif.HSYNC_in;
        if (ls) begin
            prev = cur;
            cur.delete();
            ls_cyc = cyc;
            m_vs = vif.VSYNC_in;
            m_vb = vif.VBLANK_in;
            m_locked = (cyc - evt_cyc == 2 * HT);
            evt_cyc = cyc;
        end else if (cyc - evt_cyc - 1 >= 1023) begin
            m_locked = 0;
        end
        if (vif.PIX_CE && !vif.HBLANK_in && cur.size() < LP)
            cur.push_back(vif.COLORIN);
        exp_locked = m_locked;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        check("color", int'(vif.VGA_COLOR), exp_color);
        check("hsync", int'(vif.VGA_HSYNC), exp_hs);
        check("vsync", int'(vif.VGA_VSYNC), exp_vs);
        check("blank", int'(vif.VGA_BLANK), exp_blank);
        check("locked", int'(vif.LOCKED), exp_locked);
    endtask

    task automatic send_line(input int npix, input bit sync,
                             input int hb_lo, input int hb_hi,
                             input bit vs, input bit vb,
                             input bit ramp, input int rst_clk);
        for (int p = 0; p < npix; p++) begin
            for (int ph = 0; ph < 2; ph++) begin
                res_n = (2 * p + ph != rst_clk);
                if (ph == 0) begin
                    vif.PIX_CE = 1'b1;
                    vif.HSYNC_in = sync && (p < HSL);
                    vif.HBLANK_in = !(p >= hb_lo && p < hb_hi);
                    vif.COLORIN = ramp ? 8'(p - hb_lo)
                                       : 8'($urandom);
                    vif.VSYNC_in = vs;
                    vif.VBLANK_in = vb;
                end else begin
                    vif.PIX_CE = 1'b0;
                    vif.HSYNC_in = 1'($urandom);
                    vif.HBLANK_in = 1'($urandom);
                    vif.COLORIN = 8'($urandom);
                    vif.VSYNC_in = 1'($urandom);
                    vif.VBLANK_in = 1'($urandom);
                end
                tick();
            end
        end
    endtask

    task automatic normal(input int n);
        for (int i = 0; i < n; i++)
            send_line(HT, 1, HST, HT, 0, 0, 0, -1);
    endtask

    initial begin
        res_n = 1'b0;
        vif.PIX_CE = 1'b0;
        vif.COLORIN = 8'h00;
        vif.HSYNC_in = 1'b0;
        vif.HBLANK_in = 1'b1;
        vif.VSYNC_in = 1'b0;
        vif.VBLANK_in = 1'b0;

        for (int i = 0; i < 4; i++) begin
            vif.PIX_CE = 1'($urandom);
            vif.COLORIN = 8'($urandom);
            vif.HSYNC_in = 1'($urandom);
            vif.HBLANK_in = 1'($urandom);
            vif.VSYNC_in = 1'($urandom);
            vif.VBLANK_in = 1'($urandom);
            tick();
        end
        res_n = 1'b1;

        for (int i = 0; i < 3; i++)
            send_line(HT, 1, HST, HT, 0, 0, 1, -1);
        send_line(HT, 1, HST, HST + 100, 0, 0, 0, -1);
        send_line(HT, 1, HST - 10, HT, 0, 0, 0, -1);
        normal(1);
        for (int i = 0; i < 3; i++)
            send_line(HT, 1, HST, HT, 1, 0, 0, -1);
        send_line(HT, 1, HST, HT, 0, 1, 0, -1);
        normal(2);

        send_line(3 * HT, 0, HST, HT, 0, 0, 0, -1);
        normal(2);
        send_line(300, 1, HST, HT, 0, 0, 0, -1);
        normal(3);

        send_line(HT, 1, HST, HT, 0, 0, 0, 100);
        normal(2);
        send_line(HT, 1, 0, LP, 0, 0, 0, -1);
        normal(2);

        for (int i = 0; i < 6; i++) begin
            int np;
            int lo;
            case ($urandom_range(0, 4))
                0: np = 300;
                1: np = 150;
                default: np = HT;
            endcase
            lo = $urandom_range(0, 80);
            send_line(np, 1, lo, lo + $urandom_range(0, 180),
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0), 0, -1);
        end
        normal(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
